qspi_op_seq: RTL and testbench
==============================

QSPI_OP_SEQ -- requirements
Module: qspi_op_seq

Interface
REQ-001 Parameter POLL_MAX, default 50000, maximum RDSR polls before a timeout error.
REQ-002 Parameter GAP_CYC, default 4, idle clk cycles between consecutive commands.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  operation request, sampled only in IDLE.
REQ-006 op_type  input  2  0=READ(0x03), 1=PROGRAM(0x02), 2=SECTOR_ERASE(0x20), 3=RDID(0x9F).
REQ-007 op_addr  input  24  flash byte address.
REQ-008 op_len  input  9  data byte count, 1..256, for READ/PROGRAM.
REQ-009 busy  output  1  high from request acceptance until op_done.
REQ-010 op_done  output  1  one-cycle pulse when an operation ends.
REQ-011 op_err  output  1  valid with op_done: 1=rejected or timed out.
REQ-012 last_sr  output  8  last status byte captured from RDSR.
REQ-013 start  output  1  one-cycle command strobe to qspi_fsm.
REQ-014 cmd_cfg  output  16  qspi_fsm config: [1:0]CMD lanes, [3:2]ADDR lanes, [5:4]DATA lanes, [7:6]ADDR_BYTES, [8]MODE_EN, [12:9]DUMMY, [13]DIR (1=read).
REQ-015 cmd_op  output  16  [7:0] opcode, [15:8] mode bits (always 0).
REQ-016 cmd_addr  output  32  {8'h00, op_addr}.
REQ-017 cmd_dummy  output  8  always 0.
REQ-018 cmd_len  output  32  data byte count of the current command.
REQ-019 done  input  1  qspi_fsm command-complete pulse.
REQ-020 rx_wen  input  1  qspi_fsm RX byte strobe (snooped).
REQ-021 rx_data_fifo  input  8  qspi_fsm RX byte.

Function
REQ-022 FSM states: IDLE, WREN, MAIN, POLL, GAP, FIN; each command state has an issue sub-phase (start=1 for exactly one cycle) and a wait sub-phase (held until done=1).
REQ-023 IDLE with req=1: latch op_type/op_addr/op_len and set busy=1 on the next cycle.
REQ-024 Rejection: PROGRAM with op_len=0, op_len>256, or op_addr[7:0]+op_len>256, and READ with op_len=0 or op_len>256, go straight to FIN with op_err=1 and issue no start.
REQ-025 READ: MAIN only; cmd_op[7:0]=0x03, cmd_cfg=0x2040, cmd_len=op_len.
REQ-026 RDID: MAIN only; cmd_op[7:0]=0x9F, cmd_cfg=0x2000, cmd_len=3.
REQ-027 PROGRAM: WREN (0x06, cfg 0x0000, len 0), GAP, MAIN (0x02, cfg 0x0040, len op_len), GAP, POLL.
REQ-028 SECTOR_ERASE: WREN, GAP, MAIN (0x20, cfg 0x0040, len 0), GAP, POLL.
REQ-029 POLL issues RDSR: 0x05, cfg 0x2000, len 1; the first rx_wen byte of each poll loads last_sr.
REQ-030 After each poll done: last_sr[0]=0 goes to FIN with op_err=0; otherwise increment poll_cnt, GAP, repeat POLL.
REQ-031 poll_cnt reaching POLL_MAX with WIP still 1 goes to FIN with op_err=1.
REQ-032 GAP counts GAP_CYC cycles with start=0.
REQ-033 FIN: op_done=1 for one cycle, busy=0, then IDLE; req in the FIN cycle is ignored.
REQ-034 cmd_* outputs are held stable from the start cycle until done.
REQ-035 A done pulse outside a wait sub-phase is ignored; rx_wen outside POLL wait is ignored.
REQ-036 Latency: req to first start = 2 cycles.

Reset
REQ-037 rst=1 forces IDLE at once, including mid-operation; busy, op_done, op_err, start=0; last_sr, cmd_*, and poll_cnt=0.
REQ-038 No start is issued in the cycle in which rst deasserts.

Structure
REQ-039 Opcodes, cmd_cfg templates, and op_type encodings live in package qspi_pkg, shared with qspi_fsm users.
REQ-040 No sub-module is required; the GAP/poll counters are inline.

Verification
REQ-041 READ, addr 0x001000, len 16 -> one start, cmd_op=0x0003, cmd_cfg=0x2040, cmd_len=16; op_done with op_err=0.
REQ-042 PROGRAM, addr 0x001000, len 16, flash model WIP=1 for 3 polls -> start sequence 06, 02, 05, 05, 05, 05; op_err=0; last_sr[0]=0.
REQ-043 PROGRAM, addr 0x0010F8, len 16 -> no start; op_done with op_err=1 within 3 cycles.
REQ-044 SECTOR_ERASE with POLL_MAX=4 and WIP stuck at 1 -> 06, 20, then four 05 commands; op_err=1.
REQ-045 rst pulse during the MAIN wait of PROGRAM -> busy=0 immediately; a following RDID yields cmd_len=3, op_err=0.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared QSPI command encodings: opcodes, qspi_fsm cfg templates, op types and sequencer state types.
// Pure declarations; no timing and no flow control of its own.
package qspi_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_PROGRAM      = 2'd1,
    OP_SECTOR_ERASE = 2'd2,
    OP_RDID         = 2'd3
  } op_type_e;

  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDID = 8'h9F;
  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  // cfg: [1:0] cmd lanes, [3:2] addr lanes, [5:4] data lanes, [7:6] addr bytes,
  // [8] mode en, [12:9] dummy, [13] dir (1 = read)
  localparam logic [15:0] CFG_WREN    = 16'h0000;
  localparam logic [15:0] CFG_READ    = 16'h2040;
  localparam logic [15:0] CFG_RDID    = 16'h2000;
  localparam logic [15:0] CFG_ADDR_WR = 16'h0040;
  localparam logic [15:0] CFG_RDSR    = 16'h2000;

  localparam logic [31:0] RDID_BYTES = 32'd3;
  localparam logic [31:0] RDSR_BYTES = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_MAIN,
    ST_POLL,
    ST_GAP,
    ST_FIN
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ISSUE,
    PH_WAIT
  } seq_phase_e;

  typedef struct packed {
    logic [7:0]  opc;
    logic [15:0] cfg;
    logic [31:0] len;
  } cmd_t;

  // A page program must not wrap inside its 256-byte page.
  function automatic logic op_rejected(input op_type_e t, input logic [7:0] page_off,
                                       input logic [8:0] len);
    logic [9:0] end_off;
    logic       bad_len;
    end_off = {2'b00, page_off} + {1'b0, len};
    bad_len = (len == 9'd0) || (len > 9'd256);
    case (t)
      OP_READ:    op_rejected = bad_len;
      OP_PROGRAM: op_rejected = bad_len || (end_off > 10'd256);
      default:    op_rejected = 1'b0;
    endcase
  endfunction

  function automatic cmd_t cmd_for(input seq_state_e st, input op_type_e t,
                                   input logic [8:0] len);
    cmd_t c;
    c = '0;
    case (st)
      ST_WREN: begin
        c.opc = OPC_WREN;
        c.cfg = CFG_WREN;
      end
      ST_POLL: begin
        c.opc = OPC_RDSR;
        c.cfg = CFG_RDSR;
        c.len = RDSR_BYTES;
      end
      ST_MAIN: begin
        case (t)
          OP_READ: begin
            c.opc = OPC_READ;
            c.cfg = CFG_READ;
            c.len = {23'd0, len};
          end
          OP_PROGRAM: begin
            c.opc = OPC_PP;
            c.cfg = CFG_ADDR_WR;
            c.len = {23'd0, len};
          end
          OP_SECTOR_ERASE: begin
            c.opc = OPC_SE;
            c.cfg = CFG_ADDR_WR;
          end
          default: begin
            c.opc = OPC_RDID;
            c.cfg = CFG_RDID;
            c.len = RDID_BYTES;
          end
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/qspi_op_seq.sv
// Flash operation sequencer: expands READ/PROGRAM/ERASE/RDID into WREN, main and RDSR-poll commands for qspi_fsm.
// Latency req->first start is 2 cycles; each command waits for qspi_fsm done, new req only taken in IDLE.
module qspi_op_seq
  import qspi_pkg::*;
#(
  parameter int unsigned POLL_MAX = 50000,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  op_type,
  input  logic [23:0] op_addr,
  input  logic [8:0]  op_len,
  output logic        busy,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  last_sr,
  output logic        start,
  output logic [15:0] cmd_cfg,
  output logic [15:0] cmd_op,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_dummy,
  output logic [31:0] cmd_len,
  input  logic        done,
  input  logic        rx_wen,
  input  logic [7:0]  rx_data_fifo
);

  localparam int unsigned PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
  localparam int unsigned GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX);
  localparam logic [GCW-1:0] GAP_LAST  = (GAP_CYC > 0) ? GCW'(GAP_CYC - 1) : '0;

  seq_state_e state_q, state_d;
  seq_phase_e phase_q, phase_d;
  seq_state_e gap_nxt_q, gap_nxt_d;
  logic       err_q, err_d;

  op_type_e   req_type;
  op_type_e   op_type_q;
  logic [23:0] op_addr_q;
  logic [8:0]  op_len_q;
  logic        multi_step;

  logic [GCW-1:0] gap_cnt_q;
  logic [PCW-1:0] poll_cnt_q;
  logic [PCW-1:0] poll_cnt_inc;
  logic           sr_got_q;
  logic [7:0]     last_sr_q;
  logic [7:0]     sr_now;
  cmd_t           cmd_q;
  logic           accept;
  logic           load_cmd;
  logic           cmd_state_d;

  assign req_type     = op_type_e'(op_type);
  assign accept       = (state_q == ST_IDLE) && req;
  assign multi_step   = (op_type_q == OP_PROGRAM) || (op_type_q == OP_SECTOR_ERASE);
  assign poll_cnt_inc = poll_cnt_q + PCW'(1);
  // Status used for the WIP decision, including a byte arriving together with done.
  assign sr_now       = (rx_wen && !sr_got_q) ? rx_data_fifo : last_sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_SETUP;
      gap_nxt_q <= ST_MAIN;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      gap_nxt_q <= gap_nxt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    gap_nxt_d = gap_nxt_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (op_rejected(req_type, op_addr[7:0], op_len)) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = ((req_type == OP_PROGRAM) || (req_type == OP_SECTOR_ERASE)) ?
                      ST_WREN : ST_MAIN;
            phase_d = PH_SETUP;
            err_d   = 1'b0;
          end
        end
      end
      ST_WREN, ST_MAIN, ST_POLL: begin
        case (phase_q)
          PH_SETUP: phase_d = PH_ISSUE;
          PH_ISSUE: phase_d = PH_WAIT;
          default: begin
            if (done) begin
              if (state_q == ST_WREN) begin
                state_d   = ST_GAP;
                gap_nxt_d = ST_MAIN;
              end else if (state_q == ST_MAIN) begin
                if (multi_step) begin
                  state_d   = ST_GAP;
                  gap_nxt_d = ST_POLL;
                end else begin
                  state_d = ST_FIN;
                  err_d   = 1'b0;
                end
              end else if (!sr_now[0]) begin
                state_d = ST_FIN;
                err_d   = 1'b0;
              end else if (poll_cnt_inc == POLL_LAST) begin
                state_d = ST_FIN;
                err_d   = 1'b1;
              end else begin
                state_d   = ST_GAP;
                gap_nxt_d = ST_POLL;
              end
            end
          end
        endcase
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = gap_nxt_q;
          phase_d = PH_ISSUE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        phase_d = PH_SETUP;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_SETUP;
      end
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    start   = 1'b0;
    op_done = 1'b0;
    op_err  = 1'b0;
    case (state_q)
      ST_WREN, ST_MAIN, ST_POLL: begin
        busy  = 1'b1;
        start = (phase_q == PH_ISSUE);
      end
      ST_GAP: busy = 1'b1;
      ST_FIN: begin
        op_done = 1'b1;
        op_err  = err_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign cmd_state_d = (state_d == ST_WREN) || (state_d == ST_MAIN) || (state_d == ST_POLL);
  // Command registers load on entry to the issue sub-phase and hold through the wait.
  assign load_cmd    = cmd_state_d && (phase_d == PH_ISSUE) && (phase_q != PH_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_type_q  <= OP_READ;
      op_addr_q  <= '0;
      op_len_q   <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      sr_got_q   <= 1'b0;
      last_sr_q  <= '0;
      cmd_q      <= '0;
    end else begin
      if (accept) begin
        op_type_q  <= req_type;
        op_addr_q  <= op_addr;
        op_len_q   <= op_len;
        poll_cnt_q <= '0;
      end
      gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GCW'(1) : '0;
      if (load_cmd) begin
        cmd_q <= cmd_for(state_d, op_type_q, op_len_q);
      end
      if (state_q == ST_POLL) begin
        if (phase_q == PH_ISSUE) begin
          sr_got_q <= 1'b0;
        end else if (phase_q == PH_WAIT) begin
          if (rx_wen && !sr_got_q) begin
            last_sr_q <= rx_data_fifo;
            sr_got_q  <= 1'b1;
          end
          if (done && sr_now[0]) begin
            poll_cnt_q <= poll_cnt_inc;
          end
        end
      end
    end
  end

  assign last_sr   = last_sr_q;
  assign cmd_op    = {8'h00, cmd_q.opc};
  assign cmd_cfg   = cmd_q.cfg;
  assign cmd_len   = cmd_q.len;
  assign cmd_addr  = {8'h00, op_addr_q};
  assign cmd_dummy = 8'h00;

endmodule

// File: tb/tb_qspi_op_seq.sv
// Directed bench for qspi_op_seq with a small qspi_fsm/flash responder model.
// Responder answers every start after a few cycles; RDSR returns WIP for a programmable number of polls.
module tb_qspi_op_seq;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  op_type;
  logic [23:0] op_addr;
  logic [8:0]  op_len;
  logic        busy;
  logic        op_done;
  logic        op_err;
  logic [7:0]  last_sr;
  logic        start;
  logic [15:0] cmd_cfg;
  logic [15:0] cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_dummy;
  logic [31:0] cmd_len;
  logic        done;
  logic        rx_wen;
  logic [7:0]  rx_data_fifo;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_now = 0;
  int wip_polls = 0;
  bit wip_stuck = 1'b0;
  int rdsr_base = 0;
  int rdsr_cnt = 0;
  int rst_count = 0;
  int stab_err = 0;
  logic [7:0] log_op[$];
  int         log_start[$];
  int         log_done[$];

  qspi_op_seq #(.POLL_MAX(4), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op_type(op_type), .op_addr(op_addr), .op_len(op_len),
    .busy(busy), .op_done(op_done), .op_err(op_err), .last_sr(last_sr), .start(start),
    .cmd_cfg(cmd_cfg), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_dummy(cmd_dummy),
    .cmd_len(cmd_len), .done(done), .rx_wen(rx_wen), .rx_data_fifo(rx_data_fifo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // qspi_fsm + flash stand-in
  initial begin
    logic [15:0] op_snap;
    logic [15:0] cfg_snap;
    logic [31:0] len_snap;
    int          rc_snap;
    logic [7:0]  sr;
    done = 1'b0;
    rx_wen = 1'b0;
    rx_data_fifo = 8'h00;
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        log_op.push_back(cmd_op[7:0]);
        log_start.push_back(cyc_now);
        op_snap = cmd_op;
        cfg_snap = cmd_cfg;
        len_snap = cmd_len;
        rc_snap = rst_count;
        repeat (2) @(negedge clk);
        if (op_snap[7:0] == 8'h05) begin
          sr = (wip_stuck || ((rdsr_cnt - rdsr_base) < wip_polls)) ? 8'h03 : 8'h00;
          rdsr_cnt++;
          rx_wen = 1'b1;
          rx_data_fifo = sr;
          @(negedge clk);
          rx_data_fifo = ~sr;
          @(negedge clk);
          rx_wen = 1'b0;
        end else if (cfg_snap[13]) begin
          for (int i = 0; i < int'(len_snap); i++) begin
            rx_wen = 1'b1;
            rx_data_fifo = 8'hA0 + 8'(i);
            @(negedge clk);
          end
          rx_wen = 1'b0;
        end
        if (rc_snap == rst_count &&
            (cmd_op !== op_snap || cmd_cfg !== cfg_snap || cmd_len !== len_snap))
          stab_err++;
        done = 1'b1;
        log_done.push_back(cyc_now);
        @(negedge clk);
        done = 1'b0;
      end
    end
  end

  function automatic logic [63:0] seq_from(input int base);
    logic [63:0] s;
    s = '0;
    for (int i = base; i < log_op.size(); i++) s = {s[55:0], log_op[i]};
    return s;
  endfunction

  task automatic do_op(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l,
                       output logic got, output logic err, output int cyc);
    op_type = t;
    op_addr = a;
    op_len = l;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    got = 1'b0;
    err = 1'b0;
    cyc = 1;
    while (!got && cyc < 3000) begin
      if (op_done === 1'b1) begin
        got = 1'b1;
        err = op_err;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (op_done !== 1'b0 || op_err !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b/%b exp=0/0", op_done, op_err); end
    n_cmp++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", start); end
    n_cmp++; if (last_sr !== 8'h00) begin n_fail++; $display("FAIL reset_last_sr got=%h exp=00", last_sr); end
    n_cmp++; if (cmd_op !== 16'h0000 || cmd_cfg !== 16'h0000 || cmd_len !== 32'd0 || cmd_addr !== 32'd0) begin
      n_fail++; $display("FAIL reset_cmd got op=%h cfg=%h len=%0d addr=%h exp all 0", cmd_op, cmd_cfg, cmd_len, cmd_addr); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got start=%b busy=%b exp=0/0", start, busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int   base;
    logic got;
    logic err;
    base = log_op.size();
    op_type = 2'd0; op_addr = 24'h001000; op_len = 9'd16; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (busy !== 1'b1 || start !== 1'b0) begin n_fail++; $display("FAIL read_accept got busy=%b start=%b exp=1/0", busy, start); end
    @(negedge clk);
    n_cmp++; if (start !== 1'b1) begin n_fail++; $display("FAIL read_latency got start=%b exp=1", start); end
    n_cmp++; if (cmd_op !== 16'h0003 || cmd_cfg !== 16'h2040 || cmd_len !== 32'd16) begin
      n_fail++; $display("FAIL read_cmd got op=%h cfg=%h len=%0d exp 0003/2040/16", cmd_op, cmd_cfg, cmd_len); end
    n_cmp++; if (cmd_addr !== 32'h00001000 || cmd_dummy !== 8'h00) begin
      n_fail++; $display("FAIL read_addr got addr=%h dummy=%h exp 00001000/00", cmd_addr, cmd_dummy); end
    got = 1'b0; err = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (op_done === 1'b1) begin got = 1'b1; err = op_err; end
    end
    n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL read_done got done=%b err=%b exp=1/0", got, err); end
    n_cmp++; if (log_op.size() - base !== 1) begin n_fail++; $display("FAIL read_starts got=%0d exp=1", log_op.size() - base); end
    n_cmp++; if (last_sr !== 8'h00) begin n_fail++; $display("FAIL read_sr_untouched got=%h exp=00", last_sr); end
    @(negedge clk);
    n_cmp++; if (op_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_done_pulse got done=%b busy=%b exp=0/0", op_done, busy); end
  endtask

  task automatic test_reject();
    logic [1:0]  t_tab[4] = '{2'd1, 2'd0, 2'd0, 2'd1};
    logic [23:0] a_tab[4] = '{24'h0010F8, 24'h000000, 24'h000000, 24'h001000};
    logic [8:0]  l_tab[4] = '{9'd16, 9'd0, 9'd257, 9'd0};
    int   base;
    logic got;
    logic err;
    int   cyc;
    for (int i = 0; i < 4; i++) begin
      base = log_op.size();
      do_op(t_tab[i], a_tab[i], l_tab[i], got, err, cyc);
      n_cmp++; if (got !== 1'b1 || err !== 1'b1 || cyc > 3) begin
        n_fail++; $display("FAIL reject_%0d got done=%b err=%b cyc=%0d exp=1/1/<=3", i, got, err, cyc); end
      n_cmp++; if (log_op.size() != base) begin n_fail++; $display("FAIL reject_nostart_%0d got=%0d exp=0", i, log_op.size() - base); end
      @(negedge clk);
    end
  endtask

  task automatic test_fin_ignore();
    op_type = 2'd1; op_addr = 24'h0010F8; op_len = 9'd16; req = 1'b1;
    @(negedge clk);
    n_cmp++; if (op_done !== 1'b1) begin n_fail++; $display("FAIL fin_reached got=%b exp=1", op_done); end
    op_type = 2'd0; op_len = 9'd16;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (busy !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL fin_req_ignored got busy=%b done=%b exp=0/0", busy, op_done); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_program();
    int   base;
    logic got;
    logic err;
    int   cyc;
    wip_stuck = 1'b0; wip_polls = 3; rdsr_base = rdsr_cnt;
    base = log_op.size();
    do_op(2'd1, 24'h001000, 9'd16, got, err, cyc);
    n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL prog_done got done=%b err=%b exp=1/0", got, err); end
    n_cmp++; if (log_op.size() - base !== 6 || seq_from(base) !== 64'h0000_0602_0505_0505) begin
      n_fail++; $display("FAIL prog_seq got n=%0d seq=%h exp 6/060205050505", log_op.size() - base, seq_from(base)); end
    n_cmp++; if (last_sr !== 8'h00) begin n_fail++; $display("FAIL prog_last_sr got=%h exp=00", last_sr); end
    n_cmp++; if (log_start[base+1] - log_done[base] !== 5) begin
      n_fail++; $display("FAIL prog_gap got=%0d exp=5", log_start[base+1] - log_done[base]); end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int   base;
    logic got;
    logic err;
    int   cyc;
    wip_stuck = 1'b0; wip_polls = 0; rdsr_base = rdsr_cnt;
    base = log_op.size();
    do_op(2'd1, 24'h0010F0, 9'd16, got, err, cyc);
    n_cmp++; if (got !== 1'b1 || err !== 1'b0 || seq_from(base) !== 64'h0000_0000_0006_0205) begin
      n_fail++; $display("FAIL page_edge_prog got done=%b err=%b seq=%h exp 1/0/060205", got, err, seq_from(base)); end
    @(negedge clk);
    base = log_op.size();
    do_op(2'd0, 24'h000000, 9'd256, got, err, cyc);
    n_cmp++; if (got !== 1'b1 || err !== 1'b0 || seq_from(base) !== 64'h03 || cmd_len !== 32'd256) begin
      n_fail++; $display("FAIL read_256 got done=%b err=%b seq=%h len=%0d exp 1/0/03/256", got, err, seq_from(base), cmd_len); end
    @(negedge clk);
  endtask

  task automatic test_erase_timeout();
    int   base;
    logic got;
    logic err;
    int   cyc;
    wip_stuck = 1'b1;
    base = log_op.size();
    do_op(2'd2, 24'h002000, 9'd0, got, err, cyc);
    n_cmp++; if (got !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL erase_timeout got done=%b err=%b exp=1/1", got, err); end
    n_cmp++; if (log_op.size() - base !== 6 || seq_from(base) !== 64'h0000_0620_0505_0505) begin
      n_fail++; $display("FAIL erase_seq got n=%0d seq=%h exp 6/062005050505", log_op.size() - base, seq_from(base)); end
    n_cmp++; if (last_sr !== 8'h03) begin n_fail++; $display("FAIL erase_last_sr got=%h exp=03", last_sr); end
    wip_stuck = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int   base;
    int   spurious;
    logic got;
    logic err;
    int   cyc;
    wip_polls = 3; rdsr_base = rdsr_cnt;
    base = log_op.size();
    op_type = 2'd1; op_addr = 24'h001000; op_len = 9'd16; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 200 && log_op.size() < base + 2; k++) @(negedge clk);
    n_cmp++; if (log_op.size() - base !== 2) begin n_fail++; $display("FAIL rstmid_reach_main got=%0d exp=2", log_op.size() - base); end
    @(negedge clk);
    rst = 1'b1;
    rst_count++;
    #1;
    n_cmp++; if (busy !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got busy=%b start=%b exp=0/0", busy, start); end
    n_cmp++; if (last_sr !== 8'h00 || cmd_len !== 32'd0) begin n_fail++; $display("FAIL rstmid_clear got sr=%h len=%0d exp=00/0", last_sr, cmd_len); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || op_done !== 1'b0 || start !== 1'b0) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL rstmid_stale_done got=%0d exp=0", spurious); end
    base = log_op.size();
    do_op(2'd3, 24'h000000, 9'd0, got, err, cyc);
    n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL rdid_done got done=%b err=%b exp=1/0", got, err); end
    n_cmp++; if (cmd_len !== 32'd3 || cmd_op !== 16'h009F || cmd_cfg !== 16'h2000 || seq_from(base) !== 64'h9F) begin
      n_fail++; $display("FAIL rdid_cmd got len=%0d op=%h cfg=%h seq=%h exp 3/009F/2000/9F", cmd_len, cmd_op, cmd_cfg, seq_from(base)); end
    n_cmp++; if (last_sr !== 8'h00) begin n_fail++; $display("FAIL rdid_sr_untouched got=%h exp=00", last_sr); end
    @(negedge clk);
  endtask

  task automatic test_cmd_stability();
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL cmd_stable got=%0d exp=0", stab_err); end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    op_type = 2'd0;
    op_addr = 24'd0;
    op_len = 9'd0;
    test_reset();
    test_read();
    test_reject();
    test_fin_ignore();
    test_program();
    test_boundary();
    test_erase_timeout();
    test_reset_mid();
    test_cmd_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
